// File: rtl/cmp_seq_ctrl.sv
// Byte-serial magnitude comparator: one comparator_8_bit slice walks operands MSB-first with early exit.
// Optional feature macro: CMP_SIGNED_EN (adds signed_cmp for two's-complement ordering).

module comparator_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       l_in,
  input  logic       g_in,
  input  logic       q_in,
  output logic       l,
  output logic       g,
  output logic       q
);
  // Cascade inputs only decide the result when this slice is equal.
  assign l = (a < b) | ((a == b) & l_in);
  assign g = (a > b) | ((a == b) & g_in);
  assign q = (a == b) & q_in;
endmodule

module cmp_seq_ctrl #(
  parameter  int WIDTH  = 32,
  localparam int NSLICE = WIDTH / 8,
  localparam int CW     = $clog2(NSLICE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    slices_used
`ifdef CMP_SIGNED_EN
  ,input  logic            signed_cmp
`endif
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cmp_seq_ctrl: WIDTH must be a multiple of 8 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
`ifdef CMP_SIGNED_EN
  logic             sgn_q;
`endif

  logic [7:0] slice_a;
  logic [7:0] slice_b;
  logic       cmp_l;
  logic       cmp_g;
  logic       cmp_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slice_a = ra[{idx, 3'b000} +: 8];
    slice_b = rb[{idx, 3'b000} +: 8];
`ifdef CMP_SIGNED_EN
    // Flipping the sign bit of the top byte maps two's-complement order onto unsigned order.
    if (sgn_q && idx == LAST_IDX) begin
      slice_a[7] = ~slice_a[7];
      slice_b[7] = ~slice_b[7];
    end
`endif
  end

  comparator_8_bit u_cmp (
    .a    (slice_a),
    .b    (slice_b),
    .l_in (1'b0),
    .g_in (1'b0),
    .q_in (1'b1),
    .l    (cmp_l),
    .g    (cmp_g),
    .q    (cmp_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      lt          <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      slices_used <= '0;
      idx         <= '0;
      cnt         <= '0;
      ra          <= '0;
      rb          <= '0;
`ifdef CMP_SIGNED_EN
      sgn_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ra       <= a;
            rb       <= b;
            idx      <= LAST_IDX;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef CMP_SIGNED_EN
            sgn_q    <= signed_cmp;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cmp_l || cmp_g || idx == '0) begin
            lt          <= cmp_l;
            gt          <= cmp_g;
            eq          <= cmp_q;
            slices_used <= cnt + CW'(1);
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it; no new accept overlaps.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl (WIDTH=32): directed vector table, backpressure,
// mid-run reset and randomized pairs against a byte-level reference model.

module tb_cmp_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int NS    = WIDTH / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              lt, eq, gt;
  logic [2:0]        slices_used;
`ifdef CMP_SIGNED_EN
  logic              signed_cmp = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt),
    .slices_used (slices_used)
`ifdef CMP_SIGNED_EN
    ,.signed_cmp (signed_cmp)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    int          rdly;
    bit          lt;
    bit          eq;
    bit          gt;
    int          su;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] va, vb, input bit s, input int rd,
                              input bit l, e, g, input int su, lat);
    vec_t v;
    v.a = va; v.b = vb; v.sgn = s; v.rdly = rd;
    v.lt = l; v.eq = e; v.gt = g; v.su = su; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: position of first differing byte from the MSB, and a whole-word compare.
  function automatic void model(input logic [31:0] va, vb, input bit s,
                                output bit l, e, g, output int su);
    su = NS;
    for (int i = 0; i < NS; i++) begin
      if (va[WIDTH-1-8*i -: 8] != vb[WIDTH-1-8*i -: 8]) begin
        su = i + 1;
        break;
      end
    end
    if (s) begin
      l = $signed(va) < $signed(vb);
      g = $signed(va) > $signed(vb);
    end else begin
      l = va < vb;
      g = va > vb;
    end
    e = (va == vb);
  endfunction

  // One full transaction; returns result fields and latency, checks backpressure behaviour.
  task automatic do_txn(input logic [31:0] va, vb, input bit s, input int rdly,
                        output bit gl, ge, gg, output int gsu, output int lat, output bit ok);
    int waited;
    logic [3:0] snap;
    logic [2:0] snap_su;
    ok = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("wait_in_ready_timeout", {31'b0, in_ready}, 32'd1);
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1; a = va; b = vb;
`ifdef CMP_SIGNED_EN
    signed_cmp = s;
`endif
    @(posedge clk); #1;
    // Scramble inputs after the accepting edge; the DUT must ignore them.
    in_valid = 1'b0; a = $urandom; b = $urandom;
`ifdef CMP_SIGNED_EN
    signed_cmp = ~s;
`endif
    lat = 0;
    while (lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
      ok = 1'b0;
      in_valid = 1'b0;
      return;
    end
    gl = lt; ge = eq; gg = gt; gsu = int'(slices_used);
    snap = {lt, eq, gt, in_ready};
    snap_su = slices_used;
    for (int i = 0; i < rdly; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("hold_flags_inready", {28'b0, lt, eq, gt, in_ready}, {28'b0, snap});
      check("hold_slices_used", {29'b0, slices_used}, {29'b0, snap_su});
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (rdly > 0) begin
      check("release_in_ready", {31'b0, in_ready}, 32'd1);
      check("release_out_valid", {31'b0, out_valid}, 32'd0);
    end
  endtask

  bit gl, ge, gg, ok, ml, me, mg, s;
  int gsu, lat, msu, pos;
  logic [31:0] ra, rb;
  bit saw_valid;

  initial begin
    tbl.push_back(mk(32'h5757_5757, 32'h5757_5757, 1'b0, 0, 0, 1, 0, 4, 4));
    tbl.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(32'h1234_5601, 32'h1234_5602, 1'b0, 5, 1, 0, 0, 4, 4));
    tbl.push_back(mk(32'h12FF_0000, 32'h1200_FFFF, 1'b0, 2, 0, 0, 1, 2, 2));
    tbl.push_back(mk(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0, 1, 0, 4, 4));
    tbl.push_back(mk(32'hAB00_CD01, 32'hAB00_CC01, 1'b0, 0, 0, 0, 1, 3, 3));
`ifdef CMP_SIGNED_EN
    tbl.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 0, 1, 0, 0, 4, 4));
`endif

    #12;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_flags", {29'b0, lt, eq, gt}, 32'd0);
    check("reset_slices_used", {29'b0, slices_used}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      do_txn(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].rdly, gl, ge, gg, gsu, lat, ok);
      if (ok) begin
        check("vec_flags", {29'b0, gl, ge, gg}, {29'b0, tbl[i].lt, tbl[i].eq, tbl[i].gt});
        check("vec_slices_used", gsu, tbl[i].su);
        check("vec_latency", lat, tbl[i].lat);
      end
    end

    // Reset while the second slice of four is under comparison.
    in_valid = 1'b1; a = 32'h5757_5757; b = 32'h5757_5757;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrun_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrun_rst_flags", {29'b0, lt, eq, gt}, 32'd0);
    check("midrun_rst_slices_used", {29'b0, slices_used}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrun_rst_no_result", {31'b0, saw_valid}, 32'd0);
    do_txn(32'h12FF_0000, 32'h1200_FFFF, 1'b0, 0, gl, ge, gg, gsu, lat, ok);
    if (ok) begin
      check("post_rst_flags", {29'b0, gl, ge, gg}, {29'b0, 1'b0, 1'b0, 1'b1});
      check("post_rst_slices_used", gsu, 2);
    end

    // Randomized pairs: a shared prefix of random length makes every exit position likely.
    for (int t = 0; t < 200; t++) begin
      ra = $urandom;
      rb = $urandom;
      pos = $urandom_range(0, NS);
      for (int j = 0; j < pos; j++) rb[WIDTH-1-8*j -: 8] = ra[WIDTH-1-8*j -: 8];
`ifdef CMP_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      model(ra, rb, s, ml, me, mg, msu);
      do_txn(ra, rb, s, $urandom_range(0, 3), gl, ge, gg, gsu, lat, ok);
      if (ok) begin
        check("rand_flags", {29'b0, gl, ge, gg}, {29'b0, ml, me, mg});
        check("rand_slices_used", gsu, msu);
        check("rand_latency", lat, msu);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
